// File: rtl/phi2_bus_sequencer.sv
// ---------------------------------------------------------------------------
// phi2_bus_sequencer
//
// Converts each emulated 6502 bus cycle, delimited by the phi2 rise/fall
// pulses from the edge detector, into a single transaction on a synchronous
// memory port clocked by sys_clock. Bus-cycle timing violations are latched
// in sticky error flags until err_clear.
//
// Ports
//   sys_clock    system clock, all logic on posedge
//   reset        asynchronous active-high reset
//   phi2_rise    one-cycle pulse: phi2 rising edge (start of bus cycle)
//   phi2_fall    one-cycle pulse: phi2 falling edge (end of bus cycle)
//   cpu_addr     CPU address bus
//   cpu_rw       CPU direction, 1=read 0=write
//   cpu_wdata    CPU write data
//   cpu_rdata    registered read data returned to the CPU
//   mem_addr     registered memory address
//   mem_wdata    registered memory write data
//   mem_req      one-cycle transaction request strobe
//   mem_we       write enable, meaningful while mem_req=1
//   mem_rdata    memory read data, valid with mem_ready
//   mem_ready    memory transaction complete
//   cycle_done   one-cycle pulse after each completed bus cycle
//   err_clear    synchronous clear of the sticky error flags
//   late_err     sticky: phi2_fall came before the transaction finished
//   overrun_err  sticky: phi2_rise came while a bus cycle was in flight
//   timeout_err  sticky: mem_ready not seen within TIMEOUT cycles
// ---------------------------------------------------------------------------
module phi2_bus_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  phi2_rise,
  input  logic                  phi2_fall,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_rw,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  cycle_done,
  input  logic                  err_clear,
  output logic                  late_err,
  output logic                  overrun_err,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // The counter is sized for the largest legal TIMEOUT (255). Timeout fires
  // on the WAIT cycle whose increment would bring the count to TIMEOUT.
  localparam int              CNT_W        = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic                   rw_q;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic [CNT_W-1:0]       wait_cnt;

  logic sample_cpu;
  logic issue_req;
  logic cnt_clr;
  logic cnt_inc;
  logic cap_ready;
  logic cap_timeout;
  logic deliver;
  logic set_late;
  logic set_overrun;
  logic set_timeout;

  // State register
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and action decode
  always_comb begin
    state_nxt   = state;
    sample_cpu  = 1'b0;
    issue_req   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cap_ready   = 1'b0;
    cap_timeout = 1'b0;
    deliver     = 1'b0;
    set_late    = 1'b0;
    set_overrun = 1'b0;
    set_timeout = 1'b0;

    if (phi2_rise && phi2_fall) begin
      // Both edges in one sys_clock cycle: the bus cycle is meaningless,
      // flag both and drop everything without sampling.
      set_late    = 1'b1;
      set_overrun = 1'b1;
      state_nxt   = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (phi2_rise) begin
            sample_cpu = 1'b1;
            state_nxt  = REQ;
          end
        end
        REQ: begin
          if (phi2_rise) begin
            set_overrun = 1'b1;
            sample_cpu  = 1'b1;
            state_nxt   = REQ;
          end else if (phi2_fall) begin
            set_late  = 1'b1;
            state_nxt = IDLE;
          end else begin
            issue_req = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (phi2_rise) begin
            set_overrun = 1'b1;
            sample_cpu  = 1'b1;
            state_nxt   = REQ;
          end else if (phi2_fall) begin
            set_late  = 1'b1;
            state_nxt = IDLE;
          end else if (mem_ready) begin
            // mem_ready takes priority over a coincident timeout
            cap_ready = 1'b1;
            state_nxt = DONE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            set_timeout = 1'b1;
            cap_timeout = 1'b1;
            state_nxt   = DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DONE: begin
          if (phi2_rise) begin
            set_overrun = 1'b1;
            sample_cpu  = 1'b1;
            state_nxt   = REQ;
          end else if (phi2_fall) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered datapath, memory strobes and sticky flags
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      rw_q        <= 1'b0;
      hold_q      <= '0;
      wait_cnt    <= '0;
      cpu_rdata   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      cycle_done  <= 1'b0;
      late_err    <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (sample_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        rw_q      <= cpu_rw;
      end

      mem_req    <= issue_req;
      mem_we     <= issue_req & ~rw_q;
      cycle_done <= deliver;

      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (cap_timeout) begin
        hold_q <= '1;
      end else if (cap_ready && rw_q) begin
        hold_q <= mem_rdata;
      end

      if (deliver && rw_q) begin
        cpu_rdata <= hold_q;
      end

      // A new error in the same cycle as err_clear survives the clear.
      late_err    <= set_late    | (late_err    & ~err_clear);
      overrun_err <= set_overrun | (overrun_err & ~err_clear);
      timeout_err <= set_timeout | (timeout_err & ~err_clear);
    end
  end

endmodule

// File: tb/tb_phi2_bus_sequencer.sv
module tb_phi2_bus_sequencer;

  logic        sys_clock;
  logic        reset;
  logic        phi2_rise;
  logic        phi2_fall;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        cycle_done;
  logic        err_clear;
  logic        late_err;
  logic        overrun_err;
  logic        timeout_err;

  phi2_bus_sequencer #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .TIMEOUT   (15)
  ) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .phi2_rise  (phi2_rise),
    .phi2_fall  (phi2_fall),
    .cpu_addr   (cpu_addr),
    .cpu_rw     (cpu_rw),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .cycle_done (cycle_done),
    .err_clear  (err_clear),
    .late_err   (late_err),
    .overrun_err(overrun_err),
    .timeout_err(timeout_err)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } req_t;

  req_t       exp_req_q[$];
  logic [7:0] exp_done_q[$];
  int         errors    = 0;
  int         checks    = 0;
  int         done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented memory request and completed cycle
  // against the expectations queued by the stimulus.
  always @(negedge sys_clock) begin
    if (!reset) begin
      if (mem_req) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_mem_req", {16'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          req_t e;
          e = exp_req_q.pop_front();
          chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
        end
      end
      if (cycle_done) begin
        done_seen++;
        if (exp_done_q.size() == 0) begin
          chk("unexpected_cycle_done", {24'd0, cpu_rdata}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] d;
          d = exp_done_q.pop_front();
          chk("cpu_rdata_at_done", {24'd0, cpu_rdata}, {24'd0, d});
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic rise(input logic [15:0] a, input logic rw, input logic [7:0] wd);
    cpu_addr  = a;
    cpu_rw    = rw;
    cpu_wdata = wd;
    phi2_rise = 1'b1;
    tick();
    phi2_rise = 1'b0;
  endtask

  task automatic fall();
    phi2_fall = 1'b1;
    tick();
    phi2_fall = 1'b0;
  endtask

  task automatic ready(input logic [7:0] d);
    mem_ready = 1'b1;
    mem_rdata = d;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_strobes"}, {29'd0, mem_req, mem_we, cycle_done}, 32'd0);
    chk({tag, "_errs"}, {29'd0, late_err, overrun_err, timeout_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    phi2_rise = 1'b0;
    phi2_fall = 1'b0;
    cpu_addr  = 16'h0;
    cpu_rw    = 1'b1;
    cpu_wdata = 8'h0;
    mem_rdata = 8'h0;
    mem_ready = 1'b0;
    err_clear = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Read FFFC, ready two cycles after mem_req, data 34
    exp_req_q.push_back('{addr: 16'hFFFC, we: 1'b0, wdata: 8'h00});
    rise(16'hFFFC, 1'b1, 8'h00);
    chk("req_latency_1", {31'd0, mem_req}, 32'd0);
    tick();
    chk("req_latency_2", {31'd0, mem_req}, 32'd1);
    tick();
    chk("req_single", {31'd0, mem_req}, 32'd0);
    tick();
    ready(8'h34);
    repeat (3) tick();
    chk("read_rdata_before_fall", {24'd0, cpu_rdata}, 32'd0);
    exp_done_q.push_back(8'h34);
    fall();
    chk("read_rdata_after_fall", {24'd0, cpu_rdata}, 32'h34);
    tick();
    chk("read_errs", {29'd0, late_err, overrun_err, timeout_err}, 32'd0);

    // Write A5 to 0200, ready on the cycle after mem_req
    exp_req_q.push_back('{addr: 16'h0200, we: 1'b1, wdata: 8'hA5});
    rise(16'h0200, 1'b0, 8'hA5);
    tick();
    tick();
    ready(8'hEE);
    tick();
    exp_done_q.push_back(8'h34);
    fall();
    tick();
    chk("write_rdata_kept", {24'd0, cpu_rdata}, 32'h34);

    // Timeout: read with no mem_ready
    exp_req_q.push_back('{addr: 16'h0010, we: 1'b0, wdata: 8'h00});
    rise(16'h0010, 1'b1, 8'h00);
    tick();
    repeat (14) tick();
    chk("timeout_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("timeout_set", {31'd0, timeout_err}, 32'd1);
    tick();
    exp_done_q.push_back(8'hFF);
    fall();
    chk("timeout_rdata", {24'd0, cpu_rdata}, 32'hFF);
    chk("timeout_other_errs", {30'd0, late_err, overrun_err}, 32'd0);
    clear_errs();
    chk("timeout_cleared", {31'd0, timeout_err}, 32'd0);

    // Late fall 3 cycles into WAIT, coincident with err_clear (set wins)
    exp_req_q.push_back('{addr: 16'h0300, we: 1'b0, wdata: 8'h00});
    rise(16'h0300, 1'b1, 8'h00);
    tick();
    tick();
    tick();
    err_clear = 1'b1;
    fall();
    err_clear = 1'b0;
    chk("late_set", {31'd0, late_err}, 32'd1);
    tick();
    ready(8'h77);
    repeat (3) tick();
    chk("late_rdata_kept", {24'd0, cpu_rdata}, 32'hFF);
    fall();
    tick();
    chk("late_rdata_still", {24'd0, cpu_rdata}, 32'hFF);
    clear_errs();
    chk("late_cleared", {31'd0, late_err}, 32'd0);

    // Overrun: second rise while in WAIT
    exp_req_q.push_back('{addr: 16'h5000, we: 1'b0, wdata: 8'h00});
    rise(16'h5000, 1'b1, 8'h00);
    tick();
    tick();
    exp_req_q.push_back('{addr: 16'h1234, we: 1'b0, wdata: 8'h00});
    rise(16'h1234, 1'b1, 8'h00);
    chk("overrun_set", {31'd0, overrun_err}, 32'd1);
    tick();
    tick();
    ready(8'h5A);
    tick();
    exp_done_q.push_back(8'h5A);
    fall();
    chk("overrun_rdata", {24'd0, cpu_rdata}, 32'h5A);
    tick();
    clear_errs();

    // Rise and fall together while in WAIT
    exp_req_q.push_back('{addr: 16'h0600, we: 1'b0, wdata: 8'h00});
    rise(16'h0600, 1'b1, 8'h00);
    tick();
    tick();
    phi2_rise = 1'b1;
    phi2_fall = 1'b1;
    cpu_addr  = 16'h0777;
    tick();
    phi2_rise = 1'b0;
    phi2_fall = 1'b0;
    chk("both_errs", {30'd0, late_err, overrun_err}, 32'h3);
    chk("both_no_capture", {16'd0, mem_addr}, 32'h0600);
    ready(8'h11);
    repeat (3) tick();
    fall();
    tick();
    chk("both_rdata_kept", {24'd0, cpu_rdata}, 32'h5A);

    // Asynchronous reset mid-WAIT, then a clean transaction
    exp_req_q.push_back('{addr: 16'h0400, we: 1'b0, wdata: 8'h00});
    rise(16'h0400, 1'b1, 8'h00);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge sys_clock);
    #1;
    reset = 1'b0;
    tick();
    exp_req_q.push_back('{addr: 16'h0500, we: 1'b0, wdata: 8'h00});
    rise(16'h0500, 1'b1, 8'h00);
    tick();
    tick();
    ready(8'h99);
    tick();
    exp_done_q.push_back(8'h99);
    fall();
    chk("post_reset_rdata", {24'd0, cpu_rdata}, 32'h99);
    repeat (3) tick();
    chk("post_reset_errs", {29'd0, late_err, overrun_err, timeout_err}, 32'd0);

    chk("req_queue_drained", exp_req_q.size(), 32'd0);
    chk("done_queue_drained", exp_done_q.size(), 32'd0);
    chk("cycle_done_total", done_seen, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
